// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
// Holds state/mode/speed enums and the step-period calculation.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RUNNING_LIGHT = 2'd0,
    BOUNCE        = 2'd1,
    BLINK         = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    MEDIUM = 2'd1,
    FAST   = 2'd2
  } speed_t;

  function automatic int unsigned period_cycles(
    input int unsigned freq_hz,
    input int unsigned ms
  );
    return freq_hz / 1000 * ms;
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUNNING_LIGHT: return BOUNCE;
      BOUNCE:        return BLINK;
      default:       return RUNNING_LIGHT;
    endcase
  endfunction

  function automatic speed_t next_speed(input speed_t s);
    case (s)
      SLOW:    return MEDIUM;
      MEDIUM:  return FAST;
      default: return SLOW;
    endcase
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_tick_generator.sv
// Shared period counter: pulses tick on the last cycle of the period.
// Ports: clock, reset_n, enable, restart, period_sel -> tick.
module tick_generator
  import led_pattern_pkg::*;
#(
  parameter int unsigned P_SLOW   = 10,
  parameter int unsigned P_MEDIUM = 5,
  parameter int unsigned P_FAST   = 2,
  parameter int unsigned CW       = 4
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   enable,
  input  logic   restart,
  input  speed_t period_sel,
  output logic   tick
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] last;

  always_comb begin
    case (period_sel)
      SLOW:    last = CW'(P_SLOW - 1);
      MEDIUM:  last = CW'(P_MEDIUM - 1);
      default: last = CW'(P_FAST - 1);
    endcase
  end

  assign tick = enable && !restart
             && (cnt_q == last);

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: start/pause/clear FSM driving animated LEDs.
// Ports: clock, reset_n, *_pressed pulses -> led, running, mode, speed.
// Option LED_PATTERN_SEQUENCER_AUTO_MODE_EN: auto-advance mode.
module led_pattern_sequencer
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_COUNT        = 8,
  parameter int unsigned CLOCK_FREQUENCY  = 50_000_000,
  parameter int unsigned SLOW_PERIOD_MS   = 1000,
  parameter int unsigned MEDIUM_PERIOD_MS = 500,
  parameter int unsigned FAST_PERIOD_MS   = 100
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start_stop_pressed,
  input  logic                 mode_pressed,
  input  logic                 speed_pressed,
  output logic [LED_COUNT-1:0] led,
  output logic                 running,
  output logic [1:0]           mode,
  output logic [1:0]           speed
);

  localparam int unsigned P_SLOW =
    period_cycles(CLOCK_FREQUENCY, SLOW_PERIOD_MS);
  localparam int unsigned P_MEDIUM =
    period_cycles(CLOCK_FREQUENCY, MEDIUM_PERIOD_MS);
  localparam int unsigned P_FAST =
    period_cycles(CLOCK_FREQUENCY, FAST_PERIOD_MS);
  localparam int unsigned P_MAX0 =
    (P_SLOW > P_MEDIUM) ? P_SLOW : P_MEDIUM;
  localparam int unsigned P_MAX =
    (P_MAX0 > P_FAST) ? P_MAX0 : P_FAST;
  localparam int unsigned CW =
    (P_MAX > 2) ? $clog2(P_MAX) : 1;

  state_t                state_q, state_d;
  mode_t                 mode_q, mode_d;
  speed_t                speed_q, speed_d;
  logic [LED_COUNT-1:0]  led_q, led_d;
  logic                  dir_q, dir_d;
  logic [LED_COUNT-1:0]  step_led;
  logic                  step_dir;
  logic                  clear;
  logic                  restart;
  logic                  enable;
  logic                  tick;

  function automatic logic [LED_COUNT-1:0]
    init_pattern(input mode_t m);
    if (m == BLINK) return '1;
    return {{(LED_COUNT-1){1'b0}}, 1'b1};
  endfunction

  assign clear   = mode_pressed && speed_pressed;
  assign restart = mode_pressed || speed_pressed
                || (state_q == IDLE);
  // Counter is frozen on the pausing edge so resume
  // continues from exactly where it stopped.
  assign enable  = (state_q == RUNNING)
                && !start_stop_pressed;

  tick_generator #(
    .P_SLOW   (P_SLOW),
    .P_MEDIUM (P_MEDIUM),
    .P_FAST   (P_FAST),
    .CW       (CW)
  ) u_tick (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .restart    (restart),
    .period_sel (speed_q),
    .tick       (tick)
  );

  // dir_q: 0 = left (towards MSB), 1 = right.
  always_comb begin
    step_led = led_q;
    step_dir = dir_q;
    unique case (1'b1)
      (mode_q == RUNNING_LIGHT): begin
        step_led = {led_q[LED_COUNT-2:0],
                    led_q[LED_COUNT-1]};
      end
      (mode_q == BOUNCE): begin
        if (!dir_q) begin
          step_led = led_q << 1;
          if (step_led[LED_COUNT-1]) step_dir = 1'b1;
        end else begin
          step_led = led_q >> 1;
          if (step_led[0]) step_dir = 1'b0;
        end
      end
      default: step_led = ~led_q;
    endcase
  end

`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
  localparam int unsigned SW = $clog2(2 * LED_COUNT);
  localparam logic [SW-1:0] LAST_STEP =
    SW'(2 * LED_COUNT - 1);
  logic [SW-1:0] step_q, step_d;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    speed_d = speed_q;
    led_d   = led_q;
    dir_d   = dir_q;
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
    step_d  = step_q;
`endif
    if (clear) begin
      state_d = IDLE;
      led_d   = '0;
      dir_d   = 1'b0;
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
      step_d  = '0;
`endif
    end else begin
      if (mode_pressed) begin
        mode_d = next_mode(mode_q);
        dir_d  = 1'b0;
        if (state_q != IDLE) led_d = init_pattern(mode_d);
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
        step_d = '0;
`endif
      end
      if (speed_pressed) begin
        speed_d = next_speed(speed_q);
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
        step_d  = '0;
`endif
      end
      if (start_stop_pressed) begin
        case (state_q)
          IDLE: begin
            state_d = RUNNING;
            led_d   = init_pattern(mode_d);
            dir_d   = 1'b0;
          end
          RUNNING: state_d = PAUSED;
          default: state_d = RUNNING;
        endcase
      end
      if (tick) begin
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
        if (step_q == LAST_STEP) begin
          mode_d = next_mode(mode_q);
          led_d  = init_pattern(mode_d);
          dir_d  = 1'b0;
          step_d = '0;
        end else begin
          led_d  = step_led;
          dir_d  = step_dir;
          step_d = step_q + SW'(1);
        end
`else
        led_d = step_led;
        dir_d = step_dir;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= RUNNING_LIGHT;
      speed_q <= SLOW;
      led_q   <= '0;
      dir_q   <= 1'b0;
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
      step_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      speed_q <= speed_d;
      led_q   <= led_d;
      dir_q   <= dir_d;
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
      step_q  <= step_d;
`endif
    end
  end

  assign led     = led_q;
  assign running = (state_q == RUNNING);
  assign mode    = mode_q;
  assign speed   = speed_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (LED_COUNT=4, P=10/5/2).
// Directed scenarios plus random button pulses against a reference model.
module tb_led_pattern_sequencer;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_stop_pressed = 1'b0;
  logic         mode_pressed = 1'b0;
  logic         speed_pressed = 1'b0;
  logic [N-1:0] led;
  logic         running;
  logic [1:0]   mode;
  logic [1:0]   speed;

  int checks = 0;
  int errors = 0;

  // Reference model: state 0 idle, 1 running, 2 paused.
  // m_k is the number of steps taken since the pattern was loaded.
  int m_state, m_mode, m_speed, m_k, m_elapsed, m_steps;

  led_pattern_sequencer #(
    .LED_COUNT        (N),
    .CLOCK_FREQUENCY  (1000),
    .SLOW_PERIOD_MS   (10),
    .MEDIUM_PERIOD_MS (5),
    .FAST_PERIOD_MS   (2)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .start_stop_pressed (start_stop_pressed),
    .mode_pressed       (mode_pressed),
    .speed_pressed      (speed_pressed),
    .led                (led),
    .running            (running),
    .mode               (mode),
    .speed              (speed)
  );

  always #5 clock = ~clock;

  function automatic int period_of(input int s);
    if (s == 0) return 10;
    if (s == 1) return 5;
    return 2;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_mode = 0; m_speed = 0;
    m_k = 0; m_elapsed = 0; m_steps = 0;
  endfunction

  function automatic void model_edge(input bit ss, input bit mp,
                                     input bit sp);
    if (mp && sp) begin
      m_state = 0; m_elapsed = 0; m_k = 0; m_steps = 0;
      return;
    end
    if (mp) begin
      m_mode = (m_mode + 1) % 3;
      m_elapsed = 0; m_k = 0; m_steps = 0;
    end
    if (sp) begin
      m_speed = (m_speed + 1) % 3;
      m_elapsed = 0; m_steps = 0;
    end
    if (ss) begin
      if (m_state == 0) begin
        m_state = 1; m_k = 0; m_elapsed = 0;
      end else if (m_state == 1) m_state = 2;
      else m_state = 1;
    end else if (m_state == 1 && !mp && !sp) begin
      m_elapsed++;
      if (m_elapsed == period_of(m_speed)) begin
        m_elapsed = 0;
`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
        if (m_steps == 2 * N - 1) begin
          m_mode = (m_mode + 1) % 3; m_k = 0; m_steps = 0;
        end else begin
          m_k++; m_steps++;
        end
`else
        m_k++;
`endif
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_led();
    logic [N-1:0] one;
    int p, pos;
    one = 1;
    if (m_state == 0) return '0;
    if (m_mode == 0) return one << (m_k % N);
    if (m_mode == 1) begin
      p   = m_k % (2 * (N - 1));
      pos = (p < N) ? p : 2 * (N - 1) - p;
      return one << pos;
    end
    return (m_k % 2 == 0) ? '1 : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("led", 32'(led), 32'(exp_led()));
    chk("running", 32'(running), 32'(m_state == 1));
    chk("mode", 32'(mode), 32'(m_mode));
    chk("speed", 32'(speed), 32'(m_speed));
  endtask

  task automatic cyc(input bit ss, input bit mp, input bit sp);
    start_stop_pressed = ss;
    mode_pressed       = mp;
    speed_pressed      = sp;
    @(posedge clock);
    model_edge(ss, mp, sp);
    @(negedge clock);
    start_stop_pressed = 1'b0;
    mode_pressed       = 1'b0;
    speed_pressed      = 1'b0;
    chk_all();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_led"}, 32'(led), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_mode"}, 32'(mode), 32'd0);
    chk({tag, "_speed"}, 32'(speed), 32'd0);
  endtask

  logic [N-1:0] bounce_seq [8];

  initial begin
    bounce_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0100, 4'b0010, 4'b0001, 4'b0010};
    model_reset();
    #1;
    reset_checks("por");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk_all();

    // Running light from reset
    cyc(1, 0, 0);
    chk("s1_start_led", 32'(led), 32'b0001);
    chk("s1_running", 32'(running), 32'd1);
    idle_cycles(10);
    chk("s1_step1", 32'(led), 32'b0010);
    idle_cycles(30);
    chk("s1_wrap", 32'(led), 32'b0001);

    // Bounce sequence
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("s2_b0", 32'(led), 32'(bounce_seq[0]));
    for (int i = 1; i < 8; i++) begin
      idle_cycles(10);
      chk($sformatf("s2_b%0d", i), 32'(led), 32'(bounce_seq[i]));
    end

    // Pause at counter 7, resume continues the period
    cyc(0, 1, 1);
    cyc(1, 0, 0);
    idle_cycles(7);
    cyc(1, 0, 0);
    idle_cycles(50);
    chk("s3_paused", 32'(running), 32'd0);
    chk("s3_held", 32'(led), 32'b0001);
    cyc(1, 0, 0);
    idle_cycles(2);
    chk("s3_no_step_yet", 32'(led), 32'b0001);
    idle_cycles(1);
    chk("s3_step", 32'(led), 32'b0010);

    // Blink at FAST, speed presses keep the pattern
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("s4_blink_init", 32'(led), 32'b1111);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("s4_fast", 32'(speed), 32'd2);
    chk("s4_held", 32'(led), 32'b1111);
    idle_cycles(2);
    chk("s4_toggle0", 32'(led), 32'b0000);
    idle_cycles(2);
    chk("s4_toggle1", 32'(led), 32'b1111);

    // Clear while running, then asynchronous reset mid-step
    cyc(0, 1, 1);
    chk("s5_clr_led", 32'(led), 32'd0);
    chk("s5_clr_run", 32'(running), 32'd0);
    chk("s5_clr_mode", 32'(mode), 32'd2);
    chk("s5_clr_speed", 32'(speed), 32'd2);
    cyc(1, 0, 0);
    idle_cycles(3);
    #2 reset_n = 1'b0;
    #1;
    reset_checks("async");
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    chk_all();

`ifdef LED_PATTERN_SEQUENCER_AUTO_MODE_EN
    cyc(1, 0, 0);
    idle_cycles(79);
    chk("s6_still_rl", 32'(mode), 32'd0);
    idle_cycles(1);
    chk("s6_auto_mode", 32'(mode), 32'd1);
    chk("s6_auto_led", 32'(led), 32'b0001);
    cyc(0, 1, 1);
`endif

    // Random button activity
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 59) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
